// File: rtl/mult_div_unit.sv
// Iterative shift-add multiply / restoring divide unit
// with architectural HI/LO registers and MTHI/MTLO writes.
module mult_div_unit #(
  parameter int N_BITS = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  input  logic              HI_Write,
  input  logic              LO_Write,
  input  logic [N_BITS-1:0] WriteData,
  output logic              Busy,
  output logic              Done,
  output logic              DivByZero,
  output logic [N_BITS-1:0] HI,
  output logic [N_BITS-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  cnt;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              dz;
  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] low;
  logic [N_BITS-1:0] opnd;

  logic              sa;
  logic              sb;
  logic              b_zero;
  logic [N_BITS-1:0] abs_a;
  logic [N_BITS-1:0] abs_b;

  logic [N_BITS:0]   msum;
  logic [N_BITS:0]   dsh;
  logic              ge;
  logic [N_BITS-1:0] dsub;

  logic [2*N_BITS-1:0] prod;
  logic [N_BITS-1:0]   quo;
  logic [N_BITS-1:0]   rem;

  assign sa     = Op[0] & A[N_BITS-1];
  assign sb     = Op[0] & B[N_BITS-1];
  assign b_zero = (B == '0);
  assign abs_a  = sa ? -A : A;
  assign abs_b  = sb ? -B : B;

  assign msum = {1'b0, acc}
              + {1'b0, (low[0] ? opnd : {N_BITS{1'b0}})};

  assign dsh  = {acc, low[N_BITS-1]};
  assign ge   = (dsh >= {1'b0, opnd});
  assign dsub = dsh[N_BITS-1:0] - opnd;

  assign prod = neg_q ? -{acc, low} : {acc, low};
  assign quo  = neg_q ? -low : low;
  assign rem  = neg_r ? -acc : acc;

  assign Busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic; zero divisor skips straight to FIX
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (Start)
              state_nx = (Op[1] && b_zero) ? FIX : RUN;
      RUN:  if (cnt == CNT_W'(N_BITS-1))
              state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, per-bit iteration, sign fix and HI/LO writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      acc       <= '0;
      low       <= '0;
      opnd      <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            cnt       <= '0;
            is_div    <= Op[1];
            neg_q     <= sa ^ sb;
            neg_r     <= sa;
            dz        <= Op[1] & b_zero;
            DivByZero <= 1'b0;
            if (Op[1]) begin
              acc  <= b_zero ? A : '0;
              low  <= abs_a;
              opnd <= abs_b;
            end else begin
              acc  <= '0;
              low  <= abs_b;
              opnd <= abs_a;
            end
          end else begin
            if (HI_Write) HI <= WriteData;
            if (LO_Write) LO <= WriteData;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= ge ? dsub : dsh[N_BITS-1:0];
            low <= {low[N_BITS-2:0], ge};
          end else begin
            acc <= msum[N_BITS:1];
            low <= {msum[0], low[N_BITS-1:1]};
          end
        end
        FIX: begin
          Done <= 1'b1;
          if (dz) begin
            HI        <= acc;
            LO        <= '1;
            DivByZero <= 1'b1;
          end else if (is_div) begin
            HI <= rem;
            LO <= quo;
          end else begin
            HI <= prod[2*N_BITS-1:N_BITS];
            LO <= prod[N_BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
